// File: rtl/le_alu_pkg.sv
// Shared definitions for the logic-element ALU: function codes and FSM state type.
package le_alu_pkg;

  localparam logic [3:0] LE_AND    = 4'b0000;
  localparam logic [3:0] LE_OR     = 4'b0001;
  localparam logic [3:0] LE_PASSA  = 4'b0010;
  localparam logic [3:0] LE_NOTA   = 4'b0011;
  localparam logic [3:0] LE_ANDNB  = 4'b0100;
  localparam logic [3:0] LE_ORNB   = 4'b0101;
  localparam logic [3:0] LE_PASSA2 = 4'b0110;
  localparam logic [3:0] LE_XOR    = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } le_state_e;

endpackage

// File: rtl/le_slice.sv
// Combinational SLICE-wide logic element; any code with the top bit set yields zero.
module le_slice
  import le_alu_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [3:0]       func,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] x
);

  always_comb begin
    x = '0;
    case (func)
      LE_AND:    x = a & b;
      LE_OR:     x = a | b;
      LE_PASSA:  x = a;
      LE_NOTA:   x = ~a;
      LE_ANDNB:  x = a & ~b;
      LE_ORNB:   x = a | ~b;
      LE_PASSA2: x = a;
      LE_XOR:    x = a ^ b;
      default:   x = '0;
    endcase
  end

endmodule

// File: rtl/le_slice_alu.sv
// Multi-cycle logic unit: one SLICE-wide logic element walks the operands, one slice per clock.
// Optional zero/parity flags are built only when LE_SLICE_ALU_FLAGS_EN is defined.
module le_slice_alu
  import le_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_func,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_parity,
  output logic             busy
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  le_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    func_q, func_d;
  logic [N-1:0][SLICE-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [SLICE-1:0] slc_x;
  logic accept;

  le_slice #(.SLICE(SLICE)) u_slice (
    .func (func_q),
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .x    (slc_x)
  );

  assign accept = (state_q == ST_IDLE) && in_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    func_d  = func_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          func_d  = in_func;
          a_d     = in_a;
          b_d     = in_b;
          cnt_d   = '0;
          res_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d[cnt_q] = slc_x;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      func_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      func_q  <= func_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign out_result = res_q;

`ifdef LE_SLICE_ALU_FLAGS_EN
  // Zero starts true and parity starts clear at accept; each RUN cycle folds in one slice.
  logic zero_q, zero_d, par_q, par_d;

  always_comb begin
    zero_d = zero_q;
    par_d  = par_q;
    if (accept) begin
      zero_d = 1'b1;
      par_d  = 1'b0;
    end else if (state_q == ST_RUN) begin
      zero_d = zero_q & ~(|slc_x);
      par_d  = par_q ^ (^slc_x);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      par_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      par_q  <= par_d;
    end
  end

  assign out_zero   = zero_q;
  assign out_parity = par_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign out_zero      = 1'b0;
  assign out_parity    = 1'b0;
`endif

endmodule

// File: tb/tb_le_slice_alu.sv
// Scoreboard bench for le_slice_alu: 4-slice instance under random traffic, 1-slice instance for latency.
module tb_le_slice_alu;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]  in_func = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_ready, out_valid, out_zero, out_parity, busy;
  logic [31:0] out_result;

  logic        in_valid_1 = 1'b0, out_ready_1 = 1'b0;
  logic [3:0]  in_func_1 = '0;
  logic [31:0] in_a_1 = '0, in_b_1 = '0;
  logic        in_ready_1, out_valid_1, out_zero_1, out_parity_1, busy_1;
  logic [31:0] out_result_1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        p;
    int          k;
  } exp_t;
  exp_t expq[$];

  le_slice_alu #(.WIDTH(32), .SLICE(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
    .out_parity(out_parity), .busy(busy)
  );

  le_slice_alu #(.WIDTH(32), .SLICE(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .in_func(in_func_1), .in_a(in_a_1), .in_b(in_b_1), .out_valid(out_valid_1),
    .out_ready(out_ready_1), .out_result(out_result_1), .out_zero(out_zero_1),
    .out_parity(out_parity_1), .busy(busy_1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Whole-word reference: the function table applied to full 32-bit operands.
  function automatic exp_t model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    case (f)
      4'd0: e.r = a & b;
      4'd1: e.r = a | b;
      4'd2, 4'd6: e.r = a;
      4'd3: e.r = ~a;
      4'd4: e.r = a & ~b;
      4'd5: e.r = a | ~b;
      4'd7: e.r = a ^ b;
      default: e.r = 32'h0;
    endcase
`ifdef LE_SLICE_ALU_FLAGS_EN
    e.z = (e.r == 32'h0);
    e.p = ^e.r;
`else
    e.z = 1'b0;
    e.p = 1'b0;
`endif
    e.k = 0;
    return e;
  endfunction

  // Monitor: pops on out_valid rise, then checks the outputs stay frozen while in DONE.
  bit          prev_ov = 1'b0;
  logic [31:0] held_r;
  logic        held_z, held_p;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (!prev_ov) begin
          if (expq.size() == 0) begin
            chk("spurious_out_valid", 32'(out_valid), 32'd0);
          end else begin
            e = expq.pop_front();
            chk("result", out_result, e.r);
            chk("zero", 32'(out_zero), 32'(e.z));
            chk("parity", 32'(out_parity), 32'(e.p));
            chk("latency", 32'(cyc - e.k), 32'(N));
            held_r = out_result;
            held_z = out_zero;
            held_p = out_parity;
          end
        end else begin
          chk("hold_result", out_result, held_r);
          chk("hold_flags", {30'd0, out_zero, out_parity}, {30'd0, held_z, held_p});
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic do_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit junk_req);
    exp_t e;
    int t;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_func = f; in_a = a; in_b = b;
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    e = model(f, a, b);
    e.k = cyc;
    expq.push_back(e);
    in_valid = 1'b0; in_func = 4'($urandom); in_a = $urandom; in_b = $urandom;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 20) begin
      chk("busy_run", {30'd0, busy, in_ready}, 32'd2);
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_a = $urandom; in_b = $urandom;
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 32'(out_valid), 32'd1);
      return;
    end
    in_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      if (junk_req) begin
        in_valid = 1'b1; in_func = 4'($urandom); in_a = ~a; in_b = $urandom;
      end
      @(negedge clk);
      chk("bp_in_ready", {30'd0, in_ready, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_state", {29'd0, in_ready, out_valid, busy}, 32'd4);
  endtask

  task automatic reset_mid_op();
    @(negedge clk);
    in_valid = 1'b1; in_func = 4'd1; in_a = 32'hA5A5_5A5A; in_b = 32'h0F0F_F0F0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_state", {29'd0, in_ready, out_valid, busy}, 32'd4);
    chk("rst_result", out_result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale", {30'd0, out_valid, busy}, 32'd0);
    end
  endtask

  task automatic single_slice(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int k, t;
    e = model(f, a, b);
    @(negedge clk);
    in_valid_1 = 1'b1; in_func_1 = f; in_a_1 = a; in_b_1 = b;
    @(posedge clk); #1;
    k = cyc;
    in_valid_1 = 1'b0;
    t = 0;
    @(negedge clk);
    while (!out_valid_1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("s1_latency", 32'(cyc - k), 32'd1);
    chk("s1_result", out_result_1, e.r);
    chk("s1_flags", {30'd0, out_zero_1, out_parity_1}, {30'd0, e.z, e.p});
    out_ready_1 = 1'b1;
    @(posedge clk); #1;
    out_ready_1 = 1'b0;
    chk("s1_idle", {30'd0, in_ready_1, out_valid_1}, 32'd2);
  endtask

  initial begin
    #2;
    chk("reset_state", {29'd0, in_ready, out_valid, busy}, 32'd4);
    chk("reset_outputs", {out_result[29:0], out_zero, out_parity}, 32'd0);
    chk("reset_result_hi", 32'(out_result[31:30]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(4'b0000, 32'hF0F0_1234, 32'hFF00_00FF, 0, 1'b0);
    do_op(4'b0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1'b0);
    do_op(4'b0011, 32'h0000_0000, 32'h1234_5678, 0, 1'b0);
    do_op(4'b0111, 32'h0000_0001, 32'h0000_0000, 2, 1'b0);
    do_op(4'b1010, 32'h1357_9BDF, 32'h2468_ACE0, 0, 1'b0);
    do_op(4'b0101, 32'h0000_FFFF, 32'hFFFF_0000, 5, 1'b1);
    do_op(4'b0110, 32'h8000_0001, 32'h0, 0, 1'b0);

    reset_mid_op();
    chk("q_empty_after_rst", 32'(expq.size()), 32'd0);
    expq.delete();

    for (int i = 0; i < 40; i++)
      do_op(4'($urandom_range(0, 15)), $urandom, $urandom,
            $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    single_slice(4'b0000, 32'hF0F0_1234, 32'hFF00_00FF);
    single_slice(4'b0111, 32'hCAFE_F00D, 32'h1234_5678);
    single_slice(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    repeat (3) @(negedge clk);
    chk("q_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
